clock_display_mux: RTL and testbench



---
 rtl/clock_display_mux.sv | 143 ++++++++++++++
 tb/tb_clock_display_mux.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : clock_display_mux
// Purpose  : Scans HH MM SS onto a 6-digit multiplexed common-cathode display.
//            Each frame uses a snapshot of the time, with per-field blinking.
// Revision : 1.0 - initial release
// ============================================================================
module clock_display_mux #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] hr,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       AM_PM,
  input  logic       AM_mode,
  input  logic [2:0] blink_mask,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_start
);

  localparam int            PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int            FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [2:0]    D_LAST = 3'd5;

  logic [PW-1:0] p_q, p_d;
  logic [2:0]    d_q, d_d;
  logic [FW-1:0] f_q, f_d;
  logic          blink_q, blink_d;
  logic [5:0]    hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic          ampm_q, ampm_d, ammode_q, ammode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    an_q, an_d;
  logic          fs_q, fs_d;

  logic          p_wrap, d_wrap, f_wrap;
  logic [5:0]    field_v;
  logic [5:0]    digit;
  logic          mask_bit;

  function automatic logic [6:0] seg7(input logic [5:0] v);
    case (v)
      6'd0:    seg7 = 7'h3F;
      6'd1:    seg7 = 7'h06;
      6'd2:    seg7 = 7'h5B;
      6'd3:    seg7 = 7'h4F;
      6'd4:    seg7 = 7'h66;
      6'd5:    seg7 = 7'h6D;
      6'd6:    seg7 = 7'h7D;
      6'd7:    seg7 = 7'h07;
      6'd8:    seg7 = 7'h7F;
      6'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_comb begin
    p_wrap  = (p_q == P_LAST);
    d_wrap  = p_wrap && (d_q == D_LAST);
    f_wrap  = d_wrap && (f_q == F_LAST);

    p_d     = p_wrap ? '0 : p_q + 1'b1;
    d_d     = d_q;
    if (p_wrap) d_d = (d_q == D_LAST) ? 3'd0 : d_q + 3'd1;
    f_d     = f_q;
    if (d_wrap) f_d = f_wrap ? '0 : f_q + 1'b1;
    blink_d = blink_q ^ f_wrap;

    // Shadow loads only at the frame boundary so a frame never tears.
    hr_d     = d_wrap ? hr      : hr_q;
    min_d    = d_wrap ? min     : min_q;
    sec_d    = d_wrap ? sec     : sec_q;
    ampm_d   = d_wrap ? AM_PM   : ampm_q;
    ammode_d = d_wrap ? AM_mode : ammode_q;
  end

  always_comb begin
    case (d_q[2:1])
      2'd0:    begin field_v = sec_q; mask_bit = blink_mask[0]; end
      2'd1:    begin field_v = min_q; mask_bit = blink_mask[1]; end
      default: begin field_v = hr_q;  mask_bit = blink_mask[2]; end
    endcase

    digit = d_q[0] ? (field_v / 6'd10) : (field_v % 6'd10);
    seg_d = (field_v > 6'd59) ? 7'h40 : seg7(digit);

    // First cycle of each slot is dark to avoid ghosting between digits.
    an_d = 6'b000001 << d_q;
    if ((p_q == '0) || (blink_q && mask_bit) ||
        ((d_q == 3'd5) && ammode_q && (hr_q < 6'd10)))
      an_d = '0;

    dp_d = (d_q == 3'd2) || (d_q == 3'd4) ||
           ((d_q == 3'd0) && ammode_q && ampm_q);
    fs_d = (p_q == '0) && (d_q == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q      <= '0;
      d_q      <= '0;
      f_q      <= '0;
      blink_q  <= 1'b0;
      hr_q     <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      ampm_q   <= 1'b0;
      ammode_q <= 1'b0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
      an_q     <= '0;
      fs_q     <= 1'b0;
    end else begin
      p_q      <= p_d;
      d_q      <= d_d;
      f_q      <= f_d;
      blink_q  <= blink_d;
      hr_q     <= hr_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      ampm_q   <= ampm_d;
      ammode_q <= ammode_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      fs_q     <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_display_mux
// Purpose  : Directed self-checking bench for clock_display_mux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_display_mux;

  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 6 * SD;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] hr, min, sec;
  logic       AM_PM, AM_mode;
  logic [2:0] blink_mask;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_display_mux #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .hr(hr), .min(min), .sec(sec),
    .AM_PM(AM_PM), .AM_mode(AM_mode), .blink_mask(blink_mask),
    .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
  );

  // Model: output cycle k after reset shows slot (k/SD)%6 of frame k/FRAME,
  // using the inputs captured at the end of the previous frame.
  logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int         k;
  int         m_hr, m_min, m_sec;
  logic       m_ampm, m_mode;
  logic       valid = 1'b0;
  logic [6:0] e_seg;
  logic       e_dp, e_fs;
  logic [5:0] e_an;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      k = 0; m_hr = 0; m_min = 0; m_sec = 0; m_ampm = 1'b0; m_mode = 1'b0;
      e_seg = '0; e_dp = 1'b0; e_an = '0; e_fs = 1'b0; valid = 1'b1;
    end else begin : model_step
      int p, d, frame, field, v, dig;
      p     = k % SD;
      d     = (k / SD) % 6;
      frame = k / FRAME;
      field = d / 2;
      v     = (field == 0) ? m_sec : (field == 1) ? m_min : m_hr;
      dig   = (d % 2 == 1) ? v / 10 : v % 10;
      e_seg = (v > 59) ? 7'h40 : SEG_TAB[dig];
      e_an  = '0;
      e_an[d] = 1'b1;
      if (p == 0 || (((frame / BF) % 2 == 1) && blink_mask[field]) ||
          (d == 5 && m_mode && (v / 10) == 0))
        e_an = '0;
      e_dp  = (d == 2) || (d == 4) || (d == 0 && m_mode && m_ampm);
      e_fs  = (p == 0) && (d == 0);
      if (k % FRAME == FRAME - 1) begin
        m_hr = int'(hr); m_min = int'(min); m_sec = int'(sec);
        m_ampm = AM_PM; m_mode = AM_mode;
      end
      k++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (valid) begin
      checks++;
      if ({seg, dp, an, frame_start} !== {e_seg, e_dp, e_an, e_fs}) begin
        errors++;
        $display("FAIL model t=%0t seg=%h want %h dp=%b want %b an=%b want %b fs=%b want %b",
                 $time, seg, e_seg, dp, e_dp, an, e_an, frame_start, e_fs);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  logic [6:0] c_seg [6];
  int         c_cnt [6];
  logic       c_dp  [6];
  int         c_bad;

  // Observes one whole frame starting at a frame_start cycle; caller is at a negedge.
  task automatic capture(input int poke_j, input logic [5:0] poke_v);
    int n = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("frame_start_wait", int'(frame_start === 1'b1), 1);
    c_bad = 0;
    for (int i = 0; i < 6; i++) begin c_cnt[i] = 0; c_seg[i] = '0; c_dp[i] = 1'b0; end
    for (int j = 0; j < FRAME; j++) begin
      int s;
      s = j / SD;
      if (j % SD == 0) c_seg[s] = seg;
      else if (seg !== c_seg[s]) c_bad++;
      if (an === (6'b000001 << s)) c_cnt[s]++;
      else if (an !== 6'b0) c_bad++;
      c_dp[s] = dp;
      if (j == poke_j) sec = poke_v;
      @(negedge clk);
    end
  endtask

  logic [6:0] T1_SEG [6] = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hr = 6'd12; min = 6'd34; sec = 6'd56;
    AM_PM = 1'b0; AM_mode = 1'b0; blink_mask = 3'b000;
    repeat (2) @(negedge clk);
    chk("reset_seg", int'(seg), 0);
    chk("reset_an",  int'(an), 0);
    chk("reset_dp_fs", int'({dp, frame_start}), 0);
    reset = 1'b0;
    @(negedge clk);

    // First frame after reset shows the zeroed shadow
    capture(-1, 6'd0);
    chk("f1_slot0", int'(c_seg[0]), 'h3F);
    chk("f1_slot5", int'(c_seg[5]), 'h3F);

    // Basic decode, with sec changed two cycles into the frame
    capture(2, 6'd57);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("basic_seg%0d", i), int'(c_seg[i]), int'(T1_SEG[i]));
      chk($sformatf("basic_an%0d", i), c_cnt[i], SD - 1);
      chk($sformatf("basic_dp%0d", i), int'(c_dp[i]), (i == 2 || i == 4) ? 1 : 0);
    end
    chk("basic_stable", c_bad, 0);

    capture(-1, 6'd0);
    chk("snap_slot0", int'(c_seg[0]), 'h07);
    chk("snap_slot1", int'(c_seg[1]), 'h6D);

    // 12-hour mode, PM then AM
    hr = 6'd9; AM_mode = 1'b1; AM_PM = 1'b1;
    capture(-1, 6'd0);
    capture(-1, 6'd0);
    chk("h12_an5", c_cnt[5], 0);
    chk("h12_seg4", int'(c_seg[4]), 'h6F);
    chk("h12_an4", c_cnt[4], SD - 1);
    chk("h12_pm_dp0", int'(c_dp[0]), 1);
    AM_PM = 1'b0;
    capture(-1, 6'd0);
    capture(-1, 6'd0);
    chk("h12_am_dp0", int'(c_dp[0]), 0);

    // Invalid minutes field
    AM_mode = 1'b0; hr = 6'd12; min = 6'd60;
    capture(-1, 6'd0);
    capture(-1, 6'd0);
    chk("inv_seg2", int'(c_seg[2]), 'h40);
    chk("inv_seg3", int'(c_seg[3]), 'h40);
    chk("inv_seg0", int'(c_seg[0]), 'h07);
    chk("inv_seg1", int'(c_seg[1]), 'h6D);
    chk("inv_seg4", int'(c_seg[4]), 'h5B);
    chk("inv_seg5", int'(c_seg[5]), 'h06);

    // Reset during slot 3, then blink on the minutes field
    min = 6'd34; blink_mask = 3'b010;
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_seg", int'(seg), 0);
    chk("mid_rst_an", int'(an), 0);
    chk("mid_rst_dp_fs", int'({dp, frame_start}), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_fs", int'(frame_start), 1);
    chk("post_rst_an", int'(an), 0);
    chk("post_rst_seg", int'(seg), 'h3F);
    for (int f = 1; f <= 8; f++) begin
      capture(-1, 6'd0);
      if (f == 1)
        for (int i = 0; i < 6; i++)
          chk($sformatf("rst_frame_seg%0d", i), int'(c_seg[i]), 'h3F);
      for (int i = 0; i < 6; i++)
        chk($sformatf("blink_f%0d_an%0d", f, i), c_cnt[i],
            ((i == 2 || i == 3) && (((f - 1) / 2) % 2 == 1)) ? 0 : SD - 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
